pe_mac_seq: RTL and testbench

PE multiply-accumulate sequencer sitting directly downstream of the PE ifmap scratchpad and filter scratchpad. It runs a row-stationary 1-D convolution:
- For each output it reads `filt_len` ifmap/filter pairs and accumulates their products.
- With chaining compiled in, it adds the partial sum from the neighbouring PE.
- It emits the result over a valid/ready port, then shifts the ifmap scratchpad by `stride` and waits for the scratchpad to refill.

---
 rtl/pe_mac_seq.sv | 173 +++++++++++++++++
 tb/tb_pe_mac_seq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_mac_seq.sv
// PE multiply-accumulate sequencer: row-stationary 1-D convolution over the ifmap/filter scratchpads.
// Optional neighbour partial-sum chaining is compiled in with `define PE_PSUM_CHAIN_EN.
module pe_mac_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int MEM_DEPTH  = 12,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] filt_len,
    input  logic [ADDR_WIDTH-1:0] stride,
    input  logic [7:0]            num_out,
    output logic                  busy,
    output logic                  done,
    input  logic                  ifmap_full,
    output logic                  ifmap_r_en,
    output logic [ADDR_WIDTH-1:0] ifmap_r_addr,
    input  logic [DATA_WIDTH-1:0] ifmap_dout,
    output logic                  ifmap_shift,
    output logic                  filt_r_en,
    output logic [ADDR_WIDTH-1:0] filt_r_addr,
    input  logic [DATA_WIDTH-1:0] filt_dout,
    input  logic [ACC_WIDTH-1:0]  psum_in,
    input  logic                  psum_in_valid,
    output logic                  psum_in_ready,
    output logic [ACC_WIDTH-1:0]  psum_out,
    output logic                  psum_out_valid,
    input  logic                  psum_out_ready
);

    typedef enum logic [2:0] {IDLE, WAIT_FILL, MAC, PSUM, OUT, SHIFT, DONE} state_t;

    state_t                        state;
    logic [ADDR_WIDTH-1:0]         s_last;
    logic [ADDR_WIDTH-1:0]         u_len;
    logic [ADDR_WIDTH-1:0]         shift_cnt;
    logic [7:0]                    n_out;
    logic [7:0]                    out_cnt;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic                          rd_pend;
    logic signed [2*DATA_WIDTH-1:0] prod;

    assign prod     = $signed(ifmap_dout) * $signed(filt_dout);
    assign psum_out = acc;

`ifndef PE_PSUM_CHAIN_EN
    logic unused_psum;
    assign psum_in_ready = 1'b0;
    assign unused_psum   = ^{psum_in, psum_in_valid};
`endif

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the values from before the edge, whatever the statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            s_last         <= '0;
            u_len          <= '0;
            shift_cnt      <= '0;
            n_out          <= '0;
            out_cnt        <= '0;
            acc            <= '0;
            rd_pend        <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            ifmap_r_en     <= 1'b0;
            ifmap_r_addr   <= '0;
            ifmap_shift    <= 1'b0;
            filt_r_en      <= 1'b0;
            filt_r_addr    <= '0;
            psum_out_valid <= 1'b0;
`ifdef PE_PSUM_CHAIN_EN
            psum_in_ready  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        s_last  <= (filt_len == '0) ? '0 : filt_len - ADDR_WIDTH'(1);
                        u_len   <= stride;
                        n_out   <= num_out;
                        out_cnt <= '0;
                        busy    <= 1'b1;
                        if (num_out == 8'd0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= WAIT_FILL;
                        end
                    end
                end
                WAIT_FILL: begin
                    if (ifmap_full) begin
                        acc          <= '0;
                        rd_pend      <= 1'b0;
                        ifmap_r_en   <= 1'b1;
                        filt_r_en    <= 1'b1;
                        ifmap_r_addr <= '0;
                        filt_r_addr  <= '0;
                        state        <= MAC;
                    end
                end
                MAC: begin
                    // Read data lags the issue by one cycle, so accumulate on rd_pend.
                    if (rd_pend) acc <= acc + ACC_WIDTH'(prod);
                    rd_pend <= ifmap_r_en;
                    if (ifmap_r_en) begin
                        if (ifmap_r_addr == s_last) begin
                            ifmap_r_en <= 1'b0;
                            filt_r_en  <= 1'b0;
                        end else begin
                            ifmap_r_addr <= ifmap_r_addr + ADDR_WIDTH'(1);
                            filt_r_addr  <= filt_r_addr + ADDR_WIDTH'(1);
                        end
                    end else begin
                        ifmap_r_addr <= '0;
                        filt_r_addr  <= '0;
`ifdef PE_PSUM_CHAIN_EN
                        psum_in_ready  <= 1'b1;
                        state          <= PSUM;
`else
                        psum_out_valid <= 1'b1;
                        state          <= OUT;
`endif
                    end
                end
`ifdef PE_PSUM_CHAIN_EN
                PSUM: begin
                    if (psum_in_valid) begin
                        acc            <= acc + $signed(psum_in);
                        psum_in_ready  <= 1'b0;
                        psum_out_valid <= 1'b1;
                        state          <= OUT;
                    end
                end
`endif
                OUT: begin
                    if (psum_out_ready) begin
                        psum_out_valid <= 1'b0;
                        out_cnt        <= out_cnt + 8'd1;
                        if (out_cnt + 8'd1 == n_out) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (u_len == '0) begin
                            state <= WAIT_FILL;
                        end else begin
                            ifmap_shift <= 1'b1;
                            shift_cnt   <= ADDR_WIDTH'(1);
                            state       <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (shift_cnt == u_len) begin
                        ifmap_shift <= 1'b0;
                        state       <= WAIT_FILL;
                    end else begin
                        shift_cnt <= shift_cnt + ADDR_WIDTH'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_mac_seq.sv
// Self-checking bench for pe_mac_seq: scratchpad model, directed corner jobs and random jobs
// checked against a sum-of-products reference model.
module tb_pe_mac_seq;

    localparam int AD = 4;
`ifdef PE_PSUM_CHAIN_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AD-1:0] filt_len;
    logic [AD-1:0] stride;
    logic [7:0]    num_out;
    logic          busy;
    logic          done;
    logic          ifmap_full;
    logic          ifmap_r_en;
    logic [AD-1:0] ifmap_r_addr;
    logic [15:0]   ifmap_dout;
    logic          ifmap_shift;
    logic          filt_r_en;
    logic [AD-1:0] filt_r_addr;
    logic [15:0]   filt_dout;
    logic [31:0]   psum_in;
    logic          psum_in_valid;
    logic          psum_in_ready;
    logic [31:0]   psum_out;
    logic          psum_out_valid;
    logic          psum_out_ready;

    int tests = 0;
    int fails = 0;

    logic signed [15:0] stream [64];
    logic signed [15:0] filt [16];
    logic [31:0]        psum_vals [16];
    logic [31:0]        got [16];
    int                 base;
    int                 refill_cnt;
    int                 refill_set;
    logic               full_en;
    logic               tb_clr;

    always #5 clk = ~clk;

    pe_mac_seq dut (
        .clk(clk), .reset(reset), .start(start), .filt_len(filt_len), .stride(stride),
        .num_out(num_out), .busy(busy), .done(done), .ifmap_full(ifmap_full),
        .ifmap_r_en(ifmap_r_en), .ifmap_r_addr(ifmap_r_addr), .ifmap_dout(ifmap_dout),
        .ifmap_shift(ifmap_shift), .filt_r_en(filt_r_en), .filt_r_addr(filt_r_addr),
        .filt_dout(filt_dout), .psum_in(psum_in), .psum_in_valid(psum_in_valid),
        .psum_in_ready(psum_in_ready), .psum_out(psum_out), .psum_out_valid(psum_out_valid),
        .psum_out_ready(psum_out_ready)
    );

    // Scratchpad model: ifmap is a sliding window over stream, one-cycle read latency.
    always @(posedge clk) begin
        if (ifmap_r_en) ifmap_dout <= stream[6'(base + int'(ifmap_r_addr))];
        if (filt_r_en)  filt_dout  <= filt[filt_r_addr];
        if (tb_clr) begin
            base       <= 0;
            refill_cnt <= 0;
        end else if (ifmap_shift) begin
            base       <= base + 1;
            refill_cnt <= refill_set;
        end else if (refill_cnt > 0) begin
            refill_cnt <= refill_cnt - 1;
        end
    end
    assign ifmap_full = full_en && (refill_cnt == 0);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output j = sum over k of window[j*U+k]*filt[k], plus the neighbour psum when chained.
    function automatic logic [31:0] model(input int j, input int s_eff, input int u,
                                          input logic [31:0] ps);
        longint sum;
        sum = 0;
        for (int k = 0; k < s_eff; k++)
            sum += longint'(stream[j * u + k]) * longint'(filt[k]);
        if (CHAIN) sum += longint'(ps);
        return sum[31:0];
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 64; i++) stream[i] = 16'($urandom);
        for (int i = 0; i < 16; i++) begin
            filt[i]      = 16'($urandom);
            psum_vals[i] = $urandom;
        end
    endtask

    task automatic run_job(input string tag, input int s, input int u, input int n,
                           input int full_delay, input int refill_delay,
                           input int ready_low, input int psum_delay);
        int s_eff, cyc, j, hs_cyc, done_cyc, done_cnt, reads, k_rd, shifts, vc, pw;
        int first_valid, exp_first;
        bit was_valid;
        logic [31:0] held;
        s_eff = (s == 0) ? 1 : s;
        exp_first = 3 + s_eff + full_delay;
`ifdef PE_PSUM_CHAIN_EN
        exp_first += psum_delay + 1;
`endif
        j = 0; hs_cyc = 0; done_cyc = -1; done_cnt = 0; reads = 0; k_rd = 0; shifts = 0;
        vc = 0; pw = 0; first_valid = -1; was_valid = 0; held = '0;
        @(negedge clk);
        tb_clr = 1'b1; refill_set = refill_delay; full_en = (full_delay == 0);
        start = 1'b1; filt_len = AD'(s); stride = AD'(u); num_out = 8'(n);
        @(negedge clk);
        tb_clr = 1'b0; start = 1'b0;
        cyc = 1;
        forever begin
            if (cyc > 3000) begin
                check({tag, "/cycle_budget"}, 64'(cyc), 64'(3000));
                break;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                check({tag, "/busy_after_done"}, busy, 1'b0);
                check({tag, "/done_one_cycle"}, done, 1'b0);
                break;
            end
            full_en = (cyc >= 1 + full_delay);
            // Reconfiguration attempt mid-job must be ignored.
            if (n > 0 && cyc == 2) begin
                start = 1'b1; filt_len = AD'($urandom); stride = AD'($urandom);
                num_out = 8'($urandom);
            end
            if (cyc == 3) start = 1'b0;
            check({tag, "/busy"}, busy, 1'b1);
            check({tag, "/shift_with_read"}, ifmap_shift & ifmap_r_en, 1'b0);
            check({tag, "/exclusive"}, psum_in_ready & (psum_out_valid | ifmap_r_en | ifmap_shift), 1'b0);
            if (psum_out_valid) check({tag, "/shift_in_out"}, ifmap_shift, 1'b0);
`ifndef PE_PSUM_CHAIN_EN
            check({tag, "/psum_in_ready_tied"}, psum_in_ready, 1'b0);
            psum_in_valid = 1'b1;
            psum_in       = $urandom;
`else
            if (psum_in_ready) begin
                pw++;
                psum_in_valid = (pw > psum_delay);
                psum_in       = psum_vals[j % 16];
            end else begin
                pw = 0;
                psum_in_valid = 1'b0;
            end
`endif
            if (ifmap_r_en) begin
                check({tag, "/filt_r_en"}, filt_r_en, 1'b1);
                check({tag, "/ifmap_addr"}, ifmap_r_addr, k_rd);
                check({tag, "/filt_addr"}, filt_r_addr, k_rd);
                k_rd++;
                reads++;
            end
            if (ifmap_shift) shifts++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    check({tag, "/done_cycle"}, cyc, (n == 0) ? 1 : hs_cyc + 1);
                end
            end
            if (psum_out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (was_valid) check({tag, "/held"}, psum_out, held);
                held = psum_out; was_valid = 1'b1; vc++;
                psum_out_ready = (vc > ready_low);
                if (psum_out_ready) begin
                    check({tag, $sformatf("/out%0d", j)}, psum_out,
                          model(j, s_eff, u, psum_vals[j % 16]));
                    got[j % 16] = psum_out;
                    check({tag, "/reads_per_out"}, k_rd, s_eff);
                    if (j > 0) check({tag, "/shifts_between"}, shifts, u);
                    k_rd = 0; shifts = 0; vc = 0; was_valid = 1'b0; hs_cyc = cyc; j++;
                end
            end else begin
                psum_out_ready = 1'b0;
                was_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, "/num_outputs"}, j, n);
        check({tag, "/done_count"}, done_cnt, 1);
        check({tag, "/tail_shifts"}, shifts, 0);
        if (n > 0) check({tag, "/first_valid_cycle"}, first_valid, exp_first);
        else       check({tag, "/no_reads"}, reads, 0);
        psum_out_ready = 1'b0;
        psum_in_valid  = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_first_out;
        bit found;
        reset = 1'b1; start = 1'b0; filt_len = '0; stride = '0; num_out = '0;
        psum_in = '0; psum_in_valid = 1'b0; psum_out_ready = 1'b0;
        full_en = 1'b1; tb_clr = 1'b1; refill_set = 0;
        fill_random();
        repeat (2) @(negedge clk);
        check("reset/ctrl", {busy, done, ifmap_r_en, ifmap_r_addr, ifmap_shift, filt_r_en,
                             filt_r_addr, psum_in_ready, psum_out_valid}, '0);
        check("reset/psum_out", psum_out, '0);
        reset = 1'b0;
        tb_clr = 1'b0;

        // Basic sum, unchained values 14, 20, 26, with one-cycle refill after each shift.
        for (int i = 0; i < 5; i++) stream[i] = 16'(i + 1);
        for (int i = 0; i < 3; i++) filt[i] = 16'(i + 1);
        for (int i = 0; i < 16; i++) psum_vals[i] = '0;
        run_job("basic", 3, 1, 3, 0, 1, 0, 0);
        check("basic/const0", got[0], 32'd14);
        check("basic/const1", got[1], 32'd20);
        check("basic/const2", got[2], 32'd26);

        // Signed corner: -32768 * -32768.
        stream[0] = -16'sd32768; filt[0] = -16'sd32768;
        run_job("signed", 1, 0, 1, 0, 0, 0, 0);
        check("signed/const", got[0], 32'h4000_0000);

        // Neighbour psum presented five cycles late.
        for (int i = 0; i < 5; i++) stream[i] = 16'(i + 1);
        for (int i = 0; i < 3; i++) filt[i] = 16'(i + 1);
        psum_vals[0] = 32'd100;
        run_job("chain", 3, 1, 1, 0, 0, 0, 5);
        exp_first_out = CHAIN ? 32'd114 : 32'd14;
        check("chain/const", got[0], exp_first_out);

        fill_random();
        run_job("backpressure", 3, 1, 2, 0, 0, 4, 1);
        run_job("stride2", 2, 2, 3, 0, 0, 0, 0);
        run_job("num_out0", 3, 1, 0, 0, 0, 0, 0);
        run_job("fill_stall", 2, 1, 2, 12, 2, 0, 0);
        run_job("filt_len0", 0, 1, 2, 0, 0, 1, 0);

        // Reset during MAC issue k=1, then a clean job.
        @(negedge clk);
        tb_clr = 1'b1; full_en = 1'b1; refill_set = 0;
        start = 1'b1; filt_len = 4'd3; stride = 4'd1; num_out = 8'd2;
        @(negedge clk);
        start = 1'b0; tb_clr = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (ifmap_r_en && ifmap_r_addr == 4'd1) found = 1'b1;
            else @(negedge clk);
        end
        check("rst_mid/reach_k1", found, 1'b1);
        reset = 1'b1;
        #1;
        check("rst_mid/ctrl", {busy, done, ifmap_r_en, ifmap_r_addr, ifmap_shift, filt_r_en,
                               filt_r_addr, psum_in_ready, psum_out_valid}, '0);
        check("rst_mid/psum_out", psum_out, '0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid/idle", {busy, done, ifmap_r_en}, '0);
        run_job("after_reset", 3, 1, 2, 0, 0, 0, 0);

        for (int r = 0; r < 6; r++) begin
            fill_random();
            run_job($sformatf("rand%0d", r), $urandom_range(1, 6), $urandom_range(0, 3),
                    $urandom_range(1, 4), $urandom_range(0, 3), $urandom_range(0, 2),
                    $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
